// File: rtl/axis_downsizer_if.sv
// Stream bundle for the wide-to-narrow converter: the wide input side (s_axis_*)
// and the narrow output side (m_axis_*), each with a modport for the converter and one for its neighbour.
interface axis_downsizer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int DATA_RATIO   = 8,
  parameter int S_DATA_WIDTH = DATA_RATIO * DATA_WIDTH,
  parameter int M_DATA_WIDTH = DATA_WIDTH
);
  logic [S_DATA_WIDTH-1:0] s_axis_tdata;
  logic [DATA_RATIO-1:0]   s_axis_tkeep;
  logic                    s_axis_tvalid;
  logic                    s_axis_tlast;
  logic                    s_axis_tready;
  logic [M_DATA_WIDTH-1:0] m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tlast;
  logic                    m_axis_tready;

  // Converter view: consumes wide words, produces narrow beats.
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  // Neighbour view: feeds wide words, sinks narrow beats.
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_downsizer.sv
// Wide -> narrow AXI-Stream converter: one wide word becomes eidx+1 narrow beats,
// slot 0 first, where eidx is the highest set bit of the captured tkeep.
module axis_downsizer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DATA_RATIO   = 8,
  parameter int S_DATA_WIDTH = DATA_RATIO * DATA_WIDTH,
  parameter int M_DATA_WIDTH = DATA_WIDTH
) (
  input  logic             aclk,
  input  logic             aresetn,
  axis_downsizer_if.slave  bus
);
  localparam int IW = (DATA_RATIO > 1) ? $clog2(DATA_RATIO) : 1;

  logic [DATA_RATIO-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic                                  last_q, last_d;
  logic                                  full_q, full_d;
  logic [IW-1:0]                         idx_q, idx_d;
  logic [IW-1:0]                         eidx_q, eidx_d;
  logic [IW-1:0]                         keep_eidx;
  logic [S_DATA_WIDTH-1:0]               s_word;
  logic                                  on_end, accept, m_hs;

  assign s_word = bus.s_axis_tdata;

  // Only the top set keep bit matters; holes are emitted, all-zero keep means slot 0.
  always_comb begin
    keep_eidx = '0;
    for (int k = 0; k < DATA_RATIO; k++)
      if (bus.s_axis_tkeep[k]) keep_eidx = IW'(k);
  end

  assign on_end = (idx_q == eidx_q);
  // Combinational through m_axis_tready so the next word lands on the last beat's handshake.
  assign bus.s_axis_tready = !full_q | (bus.m_axis_tready & on_end);
  assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;
  assign m_hs              = full_q & bus.m_axis_tready;

  assign bus.m_axis_tvalid = full_q;
  assign bus.m_axis_tdata  = M_DATA_WIDTH'(data_q[idx_q]);
  assign bus.m_axis_tlast  = full_q & last_q & on_end;

  always_comb begin
    data_d = data_q;
    last_d = last_q;
    full_d = full_q;
    idx_d  = idx_q;
    eidx_d = eidx_q;
    if (m_hs) begin
      if (!on_end) idx_d  = idx_q + 1'b1;
      else         full_d = 1'b0;
    end
    // A reload on the final slot overrides the drain-to-empty above.
    if (accept) begin
      data_d = s_word;
      last_d = bus.s_axis_tlast;
      eidx_d = keep_eidx;
      idx_d  = '0;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_q <= '0;
      last_q <= 1'b0;
      full_q <= 1'b0;
      idx_q  <= '0;
      eidx_q <= '0;
    end else begin
      data_q <= data_d;
      last_q <= last_d;
      full_q <= full_d;
      idx_q  <= idx_d;
      eidx_q <= eidx_d;
    end
  end
endmodule

// File: tb/tb_axis_downsizer.sv
// Directed bench for axis_downsizer: stimulus pushes expected narrow beats into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_axis_downsizer;
  localparam int DW = 8;
  localparam int DR = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  axis_downsizer_if #(.DATA_WIDTH(DW), .DATA_RATIO(DR)) ifc ();

  axis_downsizer #(.DATA_WIDTH(DW), .DATA_RATIO(DR)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (ifc)
  );

  always #5 aclk = ~aclk;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  int    last_hs_cyc = -1;
  beat_t exp_q[$];

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor, plus AXI hold check across stalled cycles.
  logic          stall_p = 1'b0;
  logic [DW-1:0] stall_d;
  logic          stall_l;
  beat_t         mon_e;
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("stall_valid", 64'(ifc.m_axis_tvalid), 64'(1));
        chk("stall_data",  64'(ifc.m_axis_tdata),  64'(stall_d));
        chk("stall_last",  64'(ifc.m_axis_tlast),  64'(stall_l));
      end
      if (ifc.m_axis_tvalid && ifc.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat (cycle %0d)", ifc.m_axis_tdata, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", 64'(ifc.m_axis_tdata), 64'(mon_e.d));
          chk("beat_last", 64'(ifc.m_axis_tlast), 64'(mon_e.l));
        end
        last_hs_cyc = cyc;
      end
      stall_p = ifc.m_axis_tvalid & ~ifc.m_axis_tready;
      stall_d = ifc.m_axis_tdata;
      stall_l = ifc.m_axis_tlast;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, output int acc_cyc);
    int    e = 0;
    int    n = 0;
    bit    acc;
    beat_t b;
    for (int i = 0; i < DR; i++) if (k[i]) e = i;
    for (int i = 0; i <= e; i++) begin
      b.d = d[i*DW +: DW];
      b.l = l && (i == e);
      exp_q.push_back(b);
    end
    ifc.s_axis_tdata  = d;
    ifc.s_axis_tkeep  = k;
    ifc.s_axis_tlast  = l;
    ifc.s_axis_tvalid = 1'b1;
    acc_cyc = -1;
    forever begin
      @(negedge aclk);
      acc = ifc.s_axis_tready;
      @(posedge aclk);
      #1;
      if (acc) begin
        acc_cyc = cyc;
        break;
      end
      n++;
      if (n > 100) begin
        n_chk++;
        $display("FAIL accept_timeout: got no acceptance expected acceptance within 100 cycles");
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  int a1, a2, h, c;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.s_axis_tdata  = '0;
    ifc.s_axis_tkeep  = '0;
    ifc.s_axis_tlast  = 1'b0;
    ifc.s_axis_tvalid = 1'b0;
    ifc.m_axis_tready = 1'b1;
    #2;
    chk("rst_mvalid", 64'(ifc.m_axis_tvalid), 64'(0));
    chk("rst_mlast",  64'(ifc.m_axis_tlast),  64'(0));
    chk("rst_mdata",  64'(ifc.m_axis_tdata),  64'(0));
    chk("rst_sready", 64'(ifc.s_axis_tready), 64'(1));
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // Full word, free-flowing sink
    send(64'h0706050403020100, 8'hFF, 1'b1, a1);
    ifc.s_axis_tvalid = 1'b0;
    for (int i = 0; i < DR; i++) begin
      @(negedge aclk);
      chk("t1_valid",  64'(ifc.m_axis_tvalid), 64'(1));
      chk("t1_data",   64'(ifc.m_axis_tdata),  64'(i));
      chk("t1_last",   64'(ifc.m_axis_tlast),  64'(i == 7));
      chk("t1_sready", 64'(ifc.s_axis_tready), 64'(i == 7));
    end
    @(posedge aclk);
    #1;
    wait_drain();
    chk("t1_last_cyc", 64'(last_hs_cyc), 64'(a1 + 7));

    // Back-to-back words, no bubble
    send(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, a1);
    send(64'h1716151413121110, 8'hFF, 1'b1, a2);
    ifc.s_axis_tvalid = 1'b0;
    chk("t2_accept_cyc", 64'(a2), 64'(a1 + 8));
    wait_drain();
    chk("t2_last_cyc", 64'(last_hs_cyc), 64'(a1 + 15));

    // Partial last word, next word accepted on the CC handshake
    send(64'h0000000000CCBBAA, 8'h07, 1'b1, a1);
    send(64'h2F2E2D2C2B2A2928, 8'hFF, 1'b1, a2);
    ifc.s_axis_tvalid = 1'b0;
    chk("t3_accept_cyc", 64'(a2), 64'(a1 + 3));
    wait_drain();

    // Backpressure 1-0-0-1
    send(64'h4746454443424140, 8'hFF, 1'b1, a1);
    ifc.s_axis_tvalid = 1'b0;
    h = 0;
    c = 0;
    while (h < DR && c < 100) begin
      ifc.m_axis_tready = pat[c % 4];
      @(negedge aclk);
      chk("t4_valid",  64'(ifc.m_axis_tvalid), 64'(1));
      chk("t4_sready", 64'(ifc.s_axis_tready), 64'(h == 7 && pat[c % 4]));
      if (pat[c % 4]) h++;
      @(posedge aclk);
      #1;
      c++;
    end
    ifc.m_axis_tready = 1'b1;
    chk("t4_beats", 64'(h), 64'(DR));
    wait_drain();

    // tkeep == 0 -> single slot-0 beat
    send(64'hA5A5A5A5A5A5A55A, 8'h00, 1'b1, a1);
    ifc.s_axis_tvalid = 1'b0;
    wait_drain();
    chk("t5_last_cyc", 64'(last_hs_cyc), 64'(a1));
    @(negedge aclk);
    chk("t5_idle", 64'(ifc.m_axis_tvalid), 64'(0));
    @(posedge aclk);
    #1;

    // Reset after beat 3 of 8
    send(64'h5756555453525150, 8'hFF, 1'b1, a1);
    ifc.s_axis_tvalid = 1'b0;
    repeat (4) @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_mvalid", 64'(ifc.m_axis_tvalid), 64'(0));
    chk("t6_sready", 64'(ifc.s_axis_tready), 64'(1));
    chk("t6_mlast",  64'(ifc.m_axis_tlast),  64'(0));
    chk("t6_mdata",  64'(ifc.m_axis_tdata),  64'(0));
    exp_q.delete();
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send(64'h6766656463626160, 8'hFF, 1'b1, a1);
    ifc.s_axis_tvalid = 1'b0;
    @(negedge aclk);
    chk("t6_first_data", 64'(ifc.m_axis_tdata), 64'(8'h60));
    @(posedge aclk);
    #1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
